counter_8bits_74169_down: RTL and testbench



---
 rtl/counter_8bits_74169_down.sv | 130 +++++++++++++
 tb/tb_counter_8bits_74169_down.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/counter_8bits_74169_down.sv
// ---------------------------------------------------------------------------
// counter_8bits_74169_down
//
// Purpose:
//   An 8-bit synchronous down counter built from two cascaded 4-bit
//   74169-style down-counter slices. Typical use is as a programmable delay
//   or terminal-count timer: load N, count down to zero, then act on Borrow.
//   The load and enable interface matches the 74163-based up counter. This
//   block counts down and reports borrow where that one reports carry.
//
// Parameters:
//   RESET_VALUE  value that {Qout2,Qout1} takes on Reset
//   SLICE_WIDTH  bits per slice; only 4 is supported
//
// Ports:
//   clk     rising-edge clock
//   Reset   synchronous, active-high reset (highest priority)
//   Load_N  synchronous parallel load, active-low (ignores P and T)
//   P       parallel count enable (both slices)
//   T       trickle count enable (low slice; gates the borrow chain)
//   Din1    load data, low nibble
//   Din2    load data, high nibble
//   Qout1   count, low nibble (registered)
//   Qout2   count, high nibble (registered)
//   Borrow  active-high borrow per slice: [0] low, [1] high (combinational)
// ---------------------------------------------------------------------------

// One 4-bit down-counter slice: a state register, the decrement path and the
// borrow (RCO-equivalent) decode.
module counter_74169_slice #(
    parameter int                     SLICE_WIDTH = 4,
    parameter logic [SLICE_WIDTH-1:0] RESET_VALUE = {SLICE_WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_n,
    input  logic                   cen_p,
    input  logic                   cen_t,
    input  logic [SLICE_WIDTH-1:0] din,
    output logic [SLICE_WIDTH-1:0] q,
    output logic                   borrow
);

    localparam logic [SLICE_WIDTH-1:0] ONE_C  = {{(SLICE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SLICE_WIDTH-1:0] ZERO_C = {SLICE_WIDTH{1'b0}};

    logic [SLICE_WIDTH-1:0] q_r;
    logic [SLICE_WIDTH-1:0] q_next_s;

    // Next-state selection, in priority order: reset, load, count, hold.
    always_comb begin
        q_next_s = q_r;
        if (reset) begin
            q_next_s = RESET_VALUE;
        end else if (!load_n) begin
            q_next_s = din;
        end else if (cen_p && cen_t) begin
            // Modulo 2^SLICE_WIDTH: zero naturally wraps to all ones.
            q_next_s = q_r - ONE_C;
        end else begin
            q_next_s = q_r;
        end
    end

    // Slice state register.
    always_ff @(posedge clk) begin
        q_r <= q_next_s;
    end

    assign q = q_r;

    // Borrow ignores cen_p, so a downstream stage can pre-decode the
    // terminal count while the count is paused.
    assign borrow = cen_t && (q_r == ZERO_C);

endmodule

// Top level: two slices with the ripple-borrow chain.
module counter_8bits_74169_down #(
    parameter logic [7:0] RESET_VALUE = 8'h00,
    parameter int         SLICE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   Load_N,
    input  logic                   P,
    input  logic                   T,
    input  logic [SLICE_WIDTH-1:0] Din1,
    input  logic [SLICE_WIDTH-1:0] Din2,
    output logic [SLICE_WIDTH-1:0] Qout1,
    output logic [SLICE_WIDTH-1:0] Qout2,
    output logic [1:0]             Borrow
);

    logic borrow_lo_s;
    logic borrow_hi_s;

    counter_74169_slice #(
        .SLICE_WIDTH (SLICE_WIDTH),
        .RESET_VALUE (RESET_VALUE[3:0])
    ) u_slice_lo (
        .clk    (clk),
        .reset  (Reset),
        .load_n (Load_N),
        .cen_p  (P),
        .cen_t  (T),
        .din    (Din1),
        .q      (Qout1),
        .borrow (borrow_lo_s)
    );

    // The high slice's trickle enable is the low slice's borrow. Both slices
    // therefore update on the same edge when the low nibble wraps (0x30 -> 0x2F).
    counter_74169_slice #(
        .SLICE_WIDTH (SLICE_WIDTH),
        .RESET_VALUE (RESET_VALUE[7:4])
    ) u_slice_hi (
        .clk    (clk),
        .reset  (Reset),
        .load_n (Load_N),
        .cen_p  (P),
        .cen_t  (borrow_lo_s),
        .din    (Din2),
        .q      (Qout2),
        .borrow (borrow_hi_s)
    );

    assign Borrow = {borrow_hi_s, borrow_lo_s};

endmodule

// File: tb/tb_counter_8bits_74169_down.sv
// ---------------------------------------------------------------------------
// tb_counter_8bits_74169_down
//
// Self-checking bench for counter_8bits_74169_down. The reference model
// treats the pair of slices as one 8-bit integer and applies these rules:
//   reset         -> 0x00
//   load          -> {Din2,Din1}
//   P and T high  -> decrement modulo 256
//   otherwise     -> hold
// The expected borrows are T & (low nibble == 0) and T & (value == 0).
// ---------------------------------------------------------------------------
module tb_counter_8bits_74169_down;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Load_N;
    logic       P;
    logic       T;
    logic [3:0] Din1;
    logic [3:0] Din2;
    logic [3:0] Qout1;
    logic [3:0] Qout2;
    logic [1:0] Borrow;

    int checks = 0;
    int errors = 0;
    int model_q = 0;
    logic [1:0] last_borrow;

    counter_8bits_74169_down #(.RESET_VALUE(8'h00), .SLICE_WIDTH(4)) dut (
        .clk    (clk),
        .Reset  (Reset),
        .Load_N (Load_N),
        .P      (P),
        .T      (T),
        .Din1   (Din1),
        .Din2   (Din2),
        .Qout1  (Qout1),
        .Qout2  (Qout2),
        .Borrow (Borrow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1:0] exp_borrow(input int q, input logic t);
        logic b0;
        logic b1;
        b0 = t && ((q % 16) == 0);
        b1 = t && (q == 0);
        return {b1, b0};
    endfunction

    // Applies one cycle of inputs. It checks Borrow before the edge and Q after it.
    task automatic step(input logic rst, input logic ld_n, input logic p, input logic t,
                        input logic [7:0] din);
        @(negedge clk);
        Reset  = rst;
        Load_N = ld_n;
        P      = p;
        T      = t;
        Din1   = din[3:0];
        Din2   = din[7:4];
        #1;
        last_borrow = Borrow;
        check_val("borrow", {6'b000000, Borrow}, {6'b000000, exp_borrow(model_q, t)});
        @(posedge clk);
        if (rst) model_q = 0;
        else if (!ld_n) model_q = int'(din);
        else if (p && t) model_q = (model_q + 255) % 256;
        #1;
        check_val("q", {Qout2, Qout1}, model_q[7:0]);
    endtask

    initial begin
        int hits;
        Reset = 1'b0; Load_N = 1'b1; P = 1'b0; T = 1'b0; Din1 = 4'h0; Din2 = 4'h0;

        // Reset, then load 0x34 with the enables low.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check_val("reset_q", {Qout2, Qout1}, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h34);
        check_val("load_q", {Qout2, Qout1}, 8'h34);
        check_val("load_borrow", {6'b000000, Borrow}, 8'h00);

        // Enable gating.
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check_val("hold_p_only", {Qout2, Qout1}, 8'h34);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check_val("hold_t_only", {Qout2, Qout1}, 8'h34);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        check_val("count_30", {Qout2, Qout1}, 8'h30);
        check_val("borrow_30", {6'b000000, Borrow}, 8'h01);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        check_val("wrap_2f", {Qout2, Qout1}, 8'h2F);
        check_val("borrow_2f", {6'b000000, Borrow}, 8'h00);

        // Full wrap: 0x01 -> 0x00 -> 0xFF, then one full period.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        check_val("zero_q", {Qout2, Qout1}, 8'h00);
        check_val("zero_borrow", {6'b000000, Borrow}, 8'h03);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        check_val("ff_q", {Qout2, Qout1}, 8'hFF);
        check_val("ff_borrow", {6'b000000, Borrow}, 8'h00);
        hits = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
            if (last_borrow[1]) hits++;
        end
        check_val("period_q", {Qout2, Qout1}, 8'hFF);
        check_val("borrow1_hits", hits[7:0], 8'h01);

        // Borrow does not depend on P.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check_val("bvp_borrow", {6'b000000, last_borrow}, 8'h03);
        check_val("bvp_q", {Qout2, Qout1}, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_val("bvp_t0", {6'b000000, last_borrow}, 8'h00);

        // Priority checks.
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h34);
        check_val("prio_reset", {Qout2, Qout1}, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h34);
        check_val("prio_load", {Qout2, Qout1}, 8'h34);

        // Reset in the middle of a count.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        check_val("mid_7c", {Qout2, Qout1}, 8'h7C);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        check_val("mid_reset", {Qout2, Qout1}, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        check_val("mid_resume", {Qout2, Qout1}, 8'hFF);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 1500; i++) begin
            logic r_rst;
            logic r_ld_n;
            logic r_p;
            logic r_t;
            logic [7:0] r_din;
            r_rst  = ($urandom_range(0, 63) == 0);
            r_ld_n = ($urandom_range(0, 15) != 0);
            r_p    = ($urandom_range(0, 3) != 0);
            r_t    = ($urandom_range(0, 3) != 0);
            r_din  = 8'($urandom_range(0, 255));
            step(r_rst, r_ld_n, r_p, r_t, r_din);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
